// File: rtl/delay_slot_tracker_pkg.sv
// CP0-facing constants shared by the delay-slot tracker and its stage registers.
package cp0_defs;

  localparam logic [31:0] RESET_PC     = 32'h0000_3000;
  localparam logic [31:0] EXC_ENTRY    = 32'h0000_4180;
  localparam int          CAUSE_BD_BIT = 31;

endpackage

// File: rtl/delay_slot_tracker_bd_stage.sv
// One pipeline stage of PC/valid/BD tracking with clear, hold and bubble controls.
module bd_stage_reg
  import cp0_defs::*;
#(
  parameter logic [31:0] RESET_PC_P = RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        hold,
  input  logic        bubble,
  input  logic [31:0] pc_in,
  input  logic        valid_in,
  input  logic        bd_in,
  output logic [31:0] pc,
  output logic        valid,
  output logic        bd
);

  // A cleared stage keeps moving the PC so the next fetch stream stays aligned,
  // while a bubble keeps PC/BD so an interrupt on it still reports a sane EPC.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= RESET_PC_P;
      valid <= 1'b0;
      bd    <= 1'b0;
    end else if (clear) begin
      pc    <= pc_in;
      valid <= 1'b0;
      bd    <= 1'b0;
    end else if (!hold) begin
      pc    <= pc_in;
      valid <= valid_in & ~bubble;
      bd    <= bd_in;
    end
  end

endmodule

// File: rtl/delay_slot_tracker.sv
// Tracks PC, valid and branch-delay-slot status through D/E/M and presents EPC to CP0.
module delay_slot_tracker
  import cp0_defs::*;
#(
  parameter logic [31:0] RESET_PC_P = RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_F,
  input  logic        delay_set_D,
  input  logic        stall,
  input  logic        flush,
  output logic        valid_D,
  output logic        valid_E,
  output logic        valid_M,
  output logic [31:0] pc_D,
  output logic [31:0] pc_E,
  output logic [31:0] pc_M,
  output logic        bd_D,
  output logic        bd_E,
  output logic        bd_M,
  output logic [31:0] epc_M
);

  logic bd_next_p0;

  function automatic logic [31:0] calc_epc(input logic [31:0] pc, input logic bd);
    return bd ? (pc - 32'd4) : pc;
  endfunction

  // BD for the incoming fetch comes from the older instruction now leaving D;
  // a killed or bubble D must never mark its successor.
  assign bd_next_p0 = delay_set_D & valid_D;

  // F -> D
  bd_stage_reg #(.RESET_PC_P(RESET_PC_P)) u_stage_d (
    .clk      (clk),
    .reset    (reset),
    .clear    (flush),
    .hold     (stall),
    .bubble   (1'b0),
    .pc_in    (pc_F),
    .valid_in (1'b1),
    .bd_in    (bd_next_p0),
    .pc       (pc_D),
    .valid    (valid_D),
    .bd       (bd_D)
  );

  // D -> E
  bd_stage_reg #(.RESET_PC_P(RESET_PC_P)) u_stage_e (
    .clk      (clk),
    .reset    (reset),
    .clear    (flush),
    .hold     (1'b0),
    .bubble   (stall),
    .pc_in    (pc_D),
    .valid_in (valid_D),
    .bd_in    (bd_D),
    .pc       (pc_E),
    .valid    (valid_E),
    .bd       (bd_E)
  );

  // E -> M
  bd_stage_reg #(.RESET_PC_P(RESET_PC_P)) u_stage_m (
    .clk      (clk),
    .reset    (reset),
    .clear    (flush),
    .hold     (1'b0),
    .bubble   (1'b0),
    .pc_in    (pc_E),
    .valid_in (valid_E),
    .bd_in    (bd_E),
    .pc       (pc_M),
    .valid    (valid_M),
    .bd       (bd_M)
  );

  assign epc_M = calc_epc(pc_M, bd_M);

endmodule

// File: tb/tb_delay_slot_tracker.sv
// Scoreboard bench for delay_slot_tracker: directed vectors with hand-computed expectations.
module tb_delay_slot_tracker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_F = 32'h3000;
  logic        delay_set_D = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        valid_D, valid_E, valid_M;
  logic [31:0] pc_D, pc_E, pc_M, epc_M;
  logic        bd_D, bd_E, bd_M;

  typedef struct {
    int          idx;
    logic [2:0]  v;
    logic [2:0]  bd;
    logic [31:0] pcd;
    logic [31:0] pce;
    logic [31:0] pcm;
    logic [31:0] epc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   vec_idx = 0;

  delay_slot_tracker dut (
    .clk         (clk),
    .reset       (reset),
    .pc_F        (pc_F),
    .delay_set_D (delay_set_D),
    .stall       (stall),
    .flush       (flush),
    .valid_D     (valid_D),
    .valid_E     (valid_E),
    .valid_M     (valid_M),
    .pc_D        (pc_D),
    .pc_E        (pc_E),
    .pc_M        (pc_M),
    .bd_D        (bd_D),
    .bd_E        (bd_E),
    .bd_M        (bd_M),
    .epc_M       (epc_M)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL vec%0d %s: got %h expected %h", idx, name, act, expv);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue the state expected after the next rising edge.
  task automatic vec(input logic r, input logic [31:0] pcf, input logic ds, input logic st, input logic fl,
                     input logic [2:0] v, input logic [2:0] bd,
                     input logic [31:0] pcd, input logic [31:0] pce, input logic [31:0] pcm,
                     input logic [31:0] epc);
    exp_t e;
    @(negedge clk);
    reset = r; pc_F = pcf; delay_set_D = ds; stall = st; flush = fl;
    e.idx = vec_idx; e.v = v; e.bd = bd; e.pcd = pcd; e.pce = pce; e.pcm = pcm; e.epc = epc;
    exp_q.push_back(e);
    vec_idx++;
  endtask

  // Monitor: the tracker presents new state every edge; compare it just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("valid_DEM", e.idx, {29'd0, valid_D, valid_E, valid_M}, {29'd0, e.v});
        chk("bd_DEM",    e.idx, {29'd0, bd_D, bd_E, bd_M},          {29'd0, e.bd});
        chk("pc_D",      e.idx, pc_D,  e.pcd);
        chk("pc_E",      e.idx, pc_E,  e.pce);
        chk("pc_M",      e.idx, pc_M,  e.pcm);
        chk("epc_M",     e.idx, epc_M, e.epc);
      end
    end
  end

  initial begin
    //   rst pc_F         ds st fl  vDEM    bdDEM   pc_D          pc_E          pc_M          epc_M
    vec(1, 32'h3000, 0, 0, 0, 3'b000, 3'b000, 32'h3000, 32'h3000, 32'h3000, 32'h3000);
    // plain stream, no delay slots
    vec(0, 32'h3000, 0, 0, 0, 3'b100, 3'b000, 32'h3000, 32'h3000, 32'h3000, 32'h3000);
    vec(0, 32'h3004, 0, 0, 0, 3'b110, 3'b000, 32'h3004, 32'h3000, 32'h3000, 32'h3000);
    vec(0, 32'h3008, 0, 0, 0, 3'b111, 3'b000, 32'h3008, 32'h3004, 32'h3000, 32'h3000);
    vec(0, 32'h300C, 0, 0, 0, 3'b111, 3'b000, 32'h300C, 32'h3008, 32'h3004, 32'h3004);
    // reset with every stage valid
    vec(1, 32'h3010, 1, 0, 0, 3'b000, 3'b000, 32'h3000, 32'h3000, 32'h3000, 32'h3000);
    // beq at 0x3000 marks 0x3004
    vec(0, 32'h3000, 0, 0, 0, 3'b100, 3'b000, 32'h3000, 32'h3000, 32'h3000, 32'h3000);
    vec(0, 32'h3004, 1, 0, 0, 3'b110, 3'b100, 32'h3004, 32'h3000, 32'h3000, 32'h3000);
    vec(0, 32'h3008, 0, 0, 0, 3'b111, 3'b010, 32'h3008, 32'h3004, 32'h3000, 32'h3000);
    vec(0, 32'h300C, 0, 0, 0, 3'b111, 3'b001, 32'h300C, 32'h3008, 32'h3004, 32'h3000);
    // stall two cycles with delay-slot 0x3008 in D
    vec(1, 32'h3000, 0, 0, 0, 3'b000, 3'b000, 32'h3000, 32'h3000, 32'h3000, 32'h3000);
    vec(0, 32'h3000, 0, 0, 0, 3'b100, 3'b000, 32'h3000, 32'h3000, 32'h3000, 32'h3000);
    vec(0, 32'h3004, 0, 0, 0, 3'b110, 3'b000, 32'h3004, 32'h3000, 32'h3000, 32'h3000);
    vec(0, 32'h3008, 1, 0, 0, 3'b111, 3'b100, 32'h3008, 32'h3004, 32'h3000, 32'h3000);
    vec(0, 32'h300C, 0, 1, 0, 3'b101, 3'b110, 32'h3008, 32'h3008, 32'h3004, 32'h3004);
    vec(0, 32'h300C, 0, 1, 0, 3'b100, 3'b111, 32'h3008, 32'h3008, 32'h3008, 32'h3004);
    vec(0, 32'h300C, 0, 0, 0, 3'b110, 3'b011, 32'h300C, 32'h3008, 32'h3008, 32'h3004);
    vec(0, 32'h3010, 0, 0, 0, 3'b111, 3'b001, 32'h3010, 32'h300C, 32'h3008, 32'h3004);
    // flush with branch 0x3014 in D; stale delay_set_D must not mark the refetch
    vec(0, 32'h3014, 0, 0, 0, 3'b111, 3'b000, 32'h3014, 32'h3010, 32'h300C, 32'h300C);
    vec(0, 32'h3018, 1, 0, 1, 3'b000, 3'b000, 32'h3018, 32'h3014, 32'h3010, 32'h3010);
    vec(0, 32'h4180, 1, 0, 0, 3'b100, 3'b000, 32'h4180, 32'h3018, 32'h3014, 32'h3014);
    // delay slot at PC 0 reaches M: EPC wraps
    vec(0, 32'h0000, 1, 0, 0, 3'b110, 3'b100, 32'h0000, 32'h4180, 32'h3018, 32'h3018);
    vec(0, 32'h0004, 0, 0, 0, 3'b111, 3'b010, 32'h0004, 32'h0000, 32'h4180, 32'h4180);
    vec(0, 32'h0008, 0, 0, 0, 3'b111, 3'b001, 32'h0008, 32'h0004, 32'h0000, 32'hFFFF_FFFC);
    // stall and flush together: flush wins, D does not hold
    vec(0, 32'h000C, 1, 1, 1, 3'b000, 3'b000, 32'h000C, 32'h0008, 32'h0004, 32'h0004);
    vec(0, 32'h4180, 1, 0, 0, 3'b100, 3'b000, 32'h4180, 32'h000C, 32'h0008, 32'h0008);
    // back-to-back branches
    vec(0, 32'h4184, 1, 0, 0, 3'b110, 3'b100, 32'h4184, 32'h4180, 32'h000C, 32'h000C);
    vec(0, 32'h4188, 1, 0, 0, 3'b111, 3'b110, 32'h4188, 32'h4184, 32'h4180, 32'h4180);
    vec(0, 32'h418C, 0, 0, 0, 3'b111, 3'b011, 32'h418C, 32'h4188, 32'h4184, 32'h4180);
    vec(0, 32'h4190, 0, 0, 0, 3'b111, 3'b001, 32'h4190, 32'h418C, 32'h4188, 32'h4184);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
